uart_rx_8n1: RTL and testbench
==============================

Name: uart_rx_8n1

Overview:
- Serial UART receiver, 8N1 framing, LSB first, line idle high.
- Sits directly upstream of the ASCII-sample buffer and drives its data_in/data_valid pair.
- Samples each bit at mid-period from a clock-count baud timer and rejects start-bit glitches.
- Flags framing errors and suppresses delivery of bad bytes.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200). Must be >= 4; elaboration error otherwise.
- HALF_BIT, CLKS_PER_BIT/2, derived localparam: cycles from start edge to start-bit mid-sample.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- rx  in  1  asynchronous serial line, idle high.
- data_out  out  8  last good received byte; holds until the next good byte.
- data_valid  out  1  one-cycle pulse: data_out has just been updated with a new byte.
- framing_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low at posedge):
  - state=IDLE; both synchronizer flops=1; prev-sample=1.
  - counter=0, bit_idx=0, shift reg=0.
  - data_out=0x00, data_valid=0, framing_err=0, busy=0.
  - A reset mid-frame aborts the frame; no pulse is emitted for it.
- Input conditioning: rx passes through a 2-flop synchronizer (rx_s), giving 2 cycles of latency. All decisions use rx_s.
- IDLE:
  - Leave only on a falling edge: prev-sample=1 and rx_s=0. Then go to START with counter=0.
  - A line that is already low, or held low after reset or after an error, does not start a frame.
- START:
  - Count to HALF_BIT-1, then sample rx_s.
  - If rx_s=0: go to DATA with counter=0 and bit_idx=0.
  - If rx_s=1: glitch; return to IDLE with no output.
- DATA:
  - Count to CLKS_PER_BIT-1, sample rx_s, shift it in LSB first, bit_idx++, counter=0.
  - After the sample with bit_idx=7, go to STOP.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rx_s.
  - If rx_s=1: data_out<=shift reg and data_valid=1 on the following cycle.
  - If rx_s=0: framing_err=1 on the following cycle; data_out unchanged.
  - Either way, return to IDLE immediately (mid-stop-bit). This allows back-to-back frames with zero idle gap.
- Pulses:
  - data_valid and framing_err are never high together.
  - Each is exactly 1 cycle wide.
  - Only one pulse per frame.
- Latency: the data_valid rising edge occurs 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles (±1) after the rx falling edge.
- Widths: counter is $clog2(CLKS_PER_BIT) bits and never exceeds CLKS_PER_BIT-1. bit_idx is 3 bits, with no wrap beyond 7.
- Break condition (rx held low):
  - Reported as a single framing_err.
  - No further activity until rx returns high and falls again.
- Unreachable state encodings return to IDLE.

Decomposition:
- Package uart_pkg contains:
  - rx_state_t enum {IDLE, START, DATA, STOP}.
  - Constant DEFAULT_CLKS_PER_BIT = 434.
- Sub-module sync_2ff: parameterised reset value, reset to 1 here. It is reused for any other async input on the board.

Test Plan (CLKS_PER_BIT=8 for simulation):
- Clean frame 0x35 ('5') after idle -> data_out=0x35, one data_valid pulse within the latency window, framing_err=0, busy low afterwards.
- Back-to-back "128" (0x31, 0x32, 0x38) with no idle bits -> three data_valid pulses in order with data_out 0x31, 0x32, 0x38; no framing_err.
- Glitch: rx low for 2 cycles then high -> busy pulses briefly, returns to IDLE, no data_valid, no framing_err.
- Frame 0x7E with stop bit 0, rx then held low for 40 cycles -> exactly one framing_err pulse; data_out keeps its previous value; no second frame until rx goes high; then frame 0x30 -> data_out=0x30.
- rst_n low for 1 cycle during DATA bit 4 -> next cycle state IDLE and all outputs 0; the next clean frame 0xA5 is received correctly as 0xA5.
- Reset released while rx=0 for 30 cycles, then high, then frame 0x39 -> no spurious byte or error; single data_valid with 0x39.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: mid-bit sampling from a cycle-count baud timer,
// start-glitch rejection, framing-error reporting with bad bytes discarded.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_err,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_param
      $error("uart_rx_8n1: CLKS_PER_BIT must be >= 4");
    end
  endgenerate

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          busy_q, busy_d;
  logic          prev_q, prev_d;
  logic [1:0]    settle_q, settle_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    prev_d   = rx_s;
    settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;

    case (state_q)
      IDLE: begin
        // The synchronizer resets to 1, so a line that is low at reset would
        // look like a falling edge; ignore edges until it holds real samples.
        if (settle_q == 2'd3 && prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Leave mid-stop-bit so a start bit right after it is still caught.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
      prev_q   <= 1'b1;
      settle_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
      prev_q   <= prev_d;
      settle_q <= settle_d;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign framing_err = ferr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1 with an 8-cycle bit period.
module tb_uart_rx_8n1;

  localparam int CPB = 8;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_err;
  logic       busy;

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .framing_err (framing_err),
    .busy        (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor, sampled on the falling edge
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         last_valid_cyc = 0;
  logic [7:0] got_mem [64];

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      got_mem[valid_cnt % 64] = data_out;
      valid_cnt = valid_cnt + 1;
      last_valid_cyc = cyc;
    end
    if (framing_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    if (data_valid === 1'b1 && framing_err === 1'b1) both_cnt = both_cnt + 1;
  end

  // scoreboard
  logic [7:0] exp_q [$];
  int rd_ptr = 0;
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic scoreboard_pop(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_expq_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_seen"}, (rd_ptr < valid_cnt) ? 32'd1 : 32'd0, 32'd1);
      if (rd_ptr < valid_cnt) begin
        check({name, "_byte"}, {24'd0, got_mem[rd_ptr % 64]}, {24'd0, e});
        rd_ptr++;
      end
    end
  endtask

  // driver tasks; all assume entry just after a rising edge
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx = bits[b];
      wait_cycles(CPB);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         gap_bits;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int v0, f0, start_cyc, lat;

    vecs[0] = '{data: 8'h35, gap_bits: 3};
    vecs[1] = '{data: 8'h31, gap_bits: 0};
    vecs[2] = '{data: 8'h32, gap_bits: 0};
    vecs[3] = '{data: 8'h38, gap_bits: 3};

    rx = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    wait_cycles(2);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_framing_err", {31'd0, framing_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    wait_cycles(20);

    // clean frame then back-to-back "128"
    for (int i = 0; i < 4; i++) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      start_cyc = cyc;
      exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, 1'b1);
      wait_cycles(vecs[i].gap_bits * CPB);
      check($sformatf("vec%0d_valid_pulses", i), valid_cnt - v0, 32'd1);
      check($sformatf("vec%0d_ferr_pulses", i), ferr_cnt - f0, 32'd0);
      check($sformatf("vec%0d_data_out", i), {24'd0, data_out}, {24'd0, vecs[i].data});
      scoreboard_pop($sformatf("vec%0d", i));
      if (i == 0) begin
        lat = last_valid_cyc - start_cyc;
        check("vec0_latency_window", (lat >= LAT - 1 && lat <= LAT + 1) ? 32'd1 : 32'd0, 32'd1);
        check("vec0_busy_after", {31'd0, busy}, 32'd0);
      end
    end

    // start-bit glitch
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    wait_cycles(2);
    rx = 1'b1;
    wait_cycles(2);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    wait_cycles(4);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    wait_cycles(3 * CPB);
    check("glitch_no_valid", valid_cnt - v0, 32'd0);
    check("glitch_no_ferr", ferr_cnt - f0, 32'd0);

    // bad stop bit, then break held low
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h7E, 1'b0);
    wait_cycles(40);
    check("break_ferr_once", ferr_cnt - f0, 32'd1);
    check("break_no_valid", valid_cnt - v0, 32'd0);
    check("break_data_held", {24'd0, data_out}, 32'h38);
    check("break_busy_low", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    wait_cycles(2 * CPB);
    check("break_release_quiet", ferr_cnt - f0, 32'd1);
    exp_q.push_back(8'h30);
    send_frame(8'h30, 1'b1);
    wait_cycles(2 * CPB);
    check("after_break_valid", valid_cnt - v0, 32'd1);
    check("after_break_data", {24'd0, data_out}, 32'h30);
    scoreboard_pop("after_break");

    // reset pulse during data bit 4 of 0x5A
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    wait_cycles(CPB);
    for (int b = 0; b < 4; b++) begin
      rx = (8'h5A >> b) & 1;
      wait_cycles(CPB);
    end
    rx = 1'b1;
    wait_cycles(CPB / 2);
    rst_n = 1'b0;
    wait_cycles(1);
    rst_n = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_data_out", {24'd0, data_out}, 32'd0);
    check("midrst_valid", {31'd0, data_valid}, 32'd0);
    check("midrst_ferr", {31'd0, framing_err}, 32'd0);
    wait_cycles(10 * CPB);
    check("midrst_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 32'd0);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_cycles(2 * CPB);
    check("post_rst_valid", valid_cnt - v0, 32'd1);
    check("post_rst_data", {24'd0, data_out}, 32'hA5);
    scoreboard_pop("post_rst");

    // reset released with the line low
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    rst_n = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(30);
    rx = 1'b1;
    wait_cycles(2 * CPB);
    check("lowrst_no_valid", valid_cnt - v0, 32'd0);
    check("lowrst_no_ferr", ferr_cnt - f0, 32'd0);
    check("lowrst_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back(8'h39);
    send_frame(8'h39, 1'b1);
    wait_cycles(2 * CPB);
    check("lowrst_frame_valid", valid_cnt - v0, 32'd1);
    check("lowrst_frame_data", {24'd0, data_out}, 32'h39);
    check("lowrst_frame_ferr", ferr_cnt - f0, 32'd0);
    scoreboard_pop("lowrst");

    // final report
    check("never_both_pulses", both_cnt, 32'd0);
    check("total_ferr", ferr_cnt, 32'd1);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("all_bytes_consumed", rd_ptr, valid_cnt);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
